// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 codes,
// data width and the byte-enable base patterns.
package lsu_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  // Indexed by funct3[1:0] (B, H, W, D), before shifting to the byte lane.
  localparam logic [7:0] BE_BASE [4] = '{8'h01, 8'h03, 8'h0F, 8'hFF};

  function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off[1:0] != 2'b00;
      2'b11:   return off != 3'b000;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: moves the addressed bytes of the returned
// doubleword down to bit 0 and sign- or zero-extends by access size.
module load_align #(
  parameter int XLEN = lsu_pkg::XLEN
) (
  input  logic [XLEN-1:0] rsp_data_i,
  input  logic [2:0]      offset_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] load_data_o
);
  import lsu_pkg::*;

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted     = rsp_data_i >> {offset_i, 3'b000};
    load_data_o = shifted;
    case (funct3_i)
      F3_B:    load_data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_H:    load_data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_W:    load_data_o = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      F3_BU:   load_data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_HU:   load_data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
      F3_WU:   load_data_o = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: load_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: checks size/alignment, issues one doubleword-aligned bus
// request per access and returns the aligned, extended load result.
//
// state | meaning
// IDLE  | accept a legal request from decode, or pulse access_fault
// REQ   | bus request held valid until bus_req_ready
// WAIT  | load issued, waiting for bus_rsp_valid
// DONE  | stall released, load_valid pulsed for loads
module load_store_unit #(
  parameter int XLEN = lsu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            stall,
  output logic            load_valid,
  output logic [XLEN-1:0] load_data,
  output logic            access_fault,
  output logic            bus_req_valid,
  input  logic            bus_req_ready,
  output logic            bus_req_we,
  output logic [XLEN-1:0] bus_req_addr,
  output logic [XLEN-1:0] bus_req_wdata,
  output logic [7:0]      bus_req_be,
  input  logic            bus_rsp_valid,
  input  logic [XLEN-1:0] bus_rsp_data
);
  import lsu_pkg::*;

  lsu_state_e      state_q, state_d;
  logic            fault_q, fault_d;
  logic            req_any, illegal, accept;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q, data_q, load_data_q, aligned;

  assign req_any = mem_read | mem_write;
  assign illegal = (mem_read & mem_write) | (funct3 == F3_BAD)
                 | (mem_write & funct3[2]) | misaligned(funct3, addr[2:0]);
  assign accept  = (state_q == ST_IDLE) & req_any & ~illegal;

  always_comb begin
    state_d = state_q;
    fault_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          if (illegal) fault_d = 1'b1;
          else         state_d = ST_REQ;
        end
      end
      ST_REQ:  if (bus_req_ready) state_d = we_q ? ST_DONE : ST_WAIT;
      ST_WAIT: if (bus_rsp_valid) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  // Request fields are captured once so the bus sees them stable through REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= '0;
      data_q      <= '0;
      load_data_q <= '0;
    end else begin
      if (accept) begin
        we_q   <= mem_write;
        f3_q   <= funct3;
        addr_q <= addr;
        data_q <= store_data;
      end
      if (state_q == ST_WAIT && bus_rsp_valid) load_data_q <= aligned;
    end
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .rsp_data_i  (bus_rsp_data),
    .offset_i    (addr_q[2:0]),
    .funct3_i    (f3_q),
    .load_data_o (aligned)
  );

  assign stall         = accept | (state_q == ST_REQ) | (state_q == ST_WAIT);
  assign load_valid    = (state_q == ST_DONE) & ~we_q;
  assign load_data     = load_data_q;
  assign access_fault  = fault_q;
  assign bus_req_valid = (state_q == ST_REQ);
  assign bus_req_we    = we_q;
  assign bus_req_addr  = {addr_q[XLEN-1:3], 3'b000};
  assign bus_req_wdata = data_q << {addr_q[2:0], 3'b000};
  assign bus_req_be    = we_q ? (BE_BASE[f3_q[1:0]] << addr_q[2:0]) : 8'hFF;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed corner cases plus random accesses
// checked against a byte-level reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [63:0] addr = '0, store_data = '0;
  logic        stall, load_valid, access_fault;
  logic [63:0] load_data;
  logic        bus_req_valid, bus_req_we;
  logic        bus_req_ready = 1'b0;
  logic [63:0] bus_req_addr, bus_req_wdata;
  logic [7:0]  bus_req_be;
  logic        bus_rsp_valid = 1'b0;
  logic [63:0] bus_rsp_data = '0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .store_data(store_data),
    .stall(stall), .load_valid(load_valid), .load_data(load_data),
    .access_fault(access_fault),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_we(bus_req_we), .bus_req_addr(bus_req_addr),
    .bus_req_wdata(bus_req_wdata), .bus_req_be(bus_req_be),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                  input logic [63:0] a);
    if (!(rd || wr)) return 1'b0;
    if (rd && wr) return 1'b0;
    if (f3 == 3'b111) return 1'b0;
    if (wr && f3[2]) return 1'b0;
    return (int'(a[2:0]) % nbytes(f3)) == 0;
  endfunction

  function automatic logic [7:0] model_be(input bit wr, input logic [2:0] f3, input int off);
    logic [7:0] be = 8'h00;
    if (!wr) return 8'hFF;
    for (int i = 0; i < nbytes(f3); i++) be[off + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] f3, input int off,
                                             input logic [63:0] rsp);
    logic [63:0] v = '0;
    int nb = nbytes(f3);
    for (int i = 0; i < nb; i++) v[8*i +: 8] = rsp[8*(off + i) +: 8];
    if (!f3[2] && nb < 8 && v[8*nb - 1])
      for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // One complete access from decode. Leaves the bench at posedge+1 with the DUT in IDLE.
  task automatic do_access(input string tag, input bit rd, input bit wr,
                           input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] sd, input logic [63:0] rsp,
                           input int rdy_dly, input int rsp_dly);
    bit ok = is_legal(rd, wr, f3, a);
    int off = int'(a[2:0]);
    logic [7:0]  exp_be = model_be(wr, f3, off);
    logic [63:0] exp_wd = sd << (8 * off);
    logic [63:0] exp_ad = a & ~64'h7;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
    bus_req_ready = (rdy_dly == 0);
    #1;
    chk({tag, " stall_idle"}, {63'd0, stall}, {63'd0, ok});
    chk({tag, " fault_pre"}, {63'd0, access_fault}, 64'd0);
    tick();
    if (!ok) begin
      mem_read = 1'b0; mem_write = 1'b0;
      chk({tag, " fault_pulse"}, {63'd0, access_fault}, 64'd1);
      chk({tag, " fault_valid"}, {63'd0, bus_req_valid}, 64'd0);
      chk({tag, " fault_stall"}, {63'd0, stall}, 64'd0);
      tick();
      chk({tag, " fault_end"}, {63'd0, access_fault}, 64'd0);
      chk({tag, " fault_valid2"}, {63'd0, bus_req_valid}, 64'd0);
      return;
    end
    // Garbage on decode and response inputs while busy must be ignored.
    for (int c = 0; c <= rdy_dly; c++) begin
      mem_read = 1'($urandom); mem_write = 1'($urandom); funct3 = 3'($urandom);
      addr = {$urandom, $urandom};
      chk({tag, " req_valid"}, {63'd0, bus_req_valid}, 64'd1);
      chk({tag, " req_stall"}, {63'd0, stall}, 64'd1);
      chk({tag, " req_we"}, {63'd0, bus_req_we}, {63'd0, wr});
      chk({tag, " req_addr"}, bus_req_addr, exp_ad);
      chk({tag, " req_be"}, {56'd0, bus_req_be}, {56'd0, exp_be});
      if (wr) chk({tag, " req_wdata"}, bus_req_wdata, exp_wd);
      if (c < rdy_dly) begin
        bus_rsp_valid = 1'b1; bus_rsp_data = ~rsp;
      end else begin
        bus_rsp_valid = 1'b0; bus_req_ready = 1'b1;
      end
      tick();
    end
    bus_req_ready = 1'b0;
    if (wr) begin
      mem_read = 1'b0; mem_write = 1'b0;
      chk({tag, " st_done_stall"}, {63'd0, stall}, 64'd0);
      chk({tag, " st_done_lv"}, {63'd0, load_valid}, 64'd0);
      chk({tag, " st_done_valid"}, {63'd0, bus_req_valid}, 64'd0);
      tick();
      chk({tag, " st_idle_lv"}, {63'd0, load_valid}, 64'd0);
      return;
    end
    for (int c = 0; c < rsp_dly; c++) begin
      chk({tag, " wait_stall"}, {63'd0, stall}, 64'd1);
      chk({tag, " wait_valid"}, {63'd0, bus_req_valid}, 64'd0);
      chk({tag, " wait_lv"}, {63'd0, load_valid}, 64'd0);
      tick();
    end
    bus_rsp_valid = 1'b1; bus_rsp_data = rsp;
    tick();
    bus_rsp_valid = 1'b0; bus_rsp_data = {$urandom, $urandom};
    mem_read = 1'b0; mem_write = 1'b0;
    chk({tag, " ld_valid"}, {63'd0, load_valid}, 64'd1);
    chk({tag, " ld_data"}, load_data, model_load(f3, off, rsp));
    chk({tag, " ld_stall"}, {63'd0, stall}, 64'd0);
    tick();
    chk({tag, " ld_valid_end"}, {63'd0, load_valid}, 64'd0);
    chk({tag, " ld_data_hold"}, load_data, model_load(f3, off, rsp));
  endtask

  initial begin
    #2;
    chk("in_reset stall", {63'd0, stall}, 64'd0);
    chk("in_reset valid", {63'd0, bus_req_valid}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    chk("reset load_valid", {63'd0, load_valid}, 64'd0);
    chk("reset load_data", load_data, 64'd0);
    chk("reset fault", {63'd0, access_fault}, 64'd0);
    chk("reset stall", {63'd0, stall}, 64'd0);

    // LB sign extension at byte 3
    do_access("lb", 1, 0, 3'b000, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 0);
    chk("lb const", load_data, 64'hFFFF_FFFF_FFFF_FF80);
    // SH into the top halfword
    do_access("sh", 0, 1, 3'b001, 64'h2006, 64'hBEEF, 64'h0, 1, 0);
    // misaligned / illegal accesses
    do_access("lw_mis", 1, 0, 3'b010, 64'h3002, 64'h0, 64'h0, 0, 0);
    do_access("rd_wr", 1, 1, 3'b011, 64'h3000, 64'h0, 64'h0, 0, 0);
    do_access("f3_111", 1, 0, 3'b111, 64'h3000, 64'h0, 64'h0, 0, 0);
    do_access("sbu", 0, 1, 3'b100, 64'h3000, 64'h0, 64'h0, 0, 0);
    // LD with ready held off 5 cycles, and zero-latency LD
    do_access("ld_slow", 1, 0, 3'b011, 64'h5008, 64'h0, 64'h0123_4567_89AB_CDEF, 5, 2);
    do_access("ld_fast", 1, 0, 3'b011, 64'h5010, 64'h0, 64'hFEDC_BA98_7654_3210, 0, 0);
    // LWU zero extension
    do_access("lwu", 1, 0, 3'b110, 64'h4004, 64'h0, 64'hF000_0000_1234_5678, 0, 1);
    chk("lwu const", load_data, 64'h0000_0000_F000_0000);

    // Reset during WAIT, then a late response for the aborted read
    mem_read = 1'b1; funct3 = 3'b011; addr = 64'h6000; bus_req_ready = 1'b1;
    tick();
    mem_read = 1'b0; tick();
    bus_req_ready = 1'b0;
    chk("abort wait stall", {63'd0, stall}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort stall", {63'd0, stall}, 64'd0);
    chk("abort valid", {63'd0, bus_req_valid}, 64'd0);
    chk("abort lv", {63'd0, load_valid}, 64'd0);
    chk("abort data", load_data, 64'd0);
    chk("abort fault", {63'd0, access_fault}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    bus_rsp_valid = 1'b1; bus_rsp_data = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    bus_rsp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("late rsp lv", {63'd0, load_valid}, 64'd0);
      chk("late rsp stall", {63'd0, stall}, 64'd0);
      chk("late rsp data", load_data, 64'd0);
      tick();
    end

    // Random accesses
    for (int n = 0; n < 40; n++) begin
      int kind = int'($urandom_range(0, 7));
      bit rd = (kind >= 4) || (kind == 0);
      bit wr = (kind <= 3);
      do_access("rand", rd, wr, 3'($urandom), {$urandom, $urandom},
                {$urandom, $urandom}, {$urandom, $urandom},
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
